// File: rtl/gate_test_sequencer.sv
// Clocked stimulus/check sequencer for small combinational gate datapaths.
// Optional macro GATE_SEQ_STOP_ON_ERR_EN: end the sweep at the first mismatching vector.
module gate_test_sequencer #(
  parameter int N_IN        = 2,
  parameter int HOLD_CYCLES = 10,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op_sel,
  output logic [N_IN-1:0]  dut_in,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [N_IN-1:0]  vec_idx,
  output logic [1:0]       state_dbg
);

  // Hold counter only ever holds HOLD_CYCLES-1 down to 0.
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]    HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [N_IN-1:0]  VEC_LAST  = {N_IN{1'b1}};
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q, state_n;
  logic [1:0]       op_q, op_n;
  logic [HW-1:0]    hold_q, hold_n;
  logic [N_IN-1:0]  vec_q, vec_n;
  logic [ERR_W-1:0] err_q, err_n, err_upd;
  logic             pass_q, pass_n;
  logic             expected, mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 2'd0;
      hold_q  <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      op_q    <= op_n;
      hold_q  <= hold_n;
      vec_q   <= vec_n;
      err_q   <= err_n;
      pass_q  <= pass_n;
    end
  end

  always_comb begin
    expected = 1'b0;
    case (op_q)
      2'd0:    expected = &vec_q;
      2'd1:    expected = |vec_q;
      2'd2:    expected = ^vec_q;
      default: expected = ~&vec_q;
    endcase
    mismatch = (dut_out != expected);
    // Saturating increment: a stuck output must never wrap the count back to a pass.
    err_upd  = (mismatch && err_q != ERR_MAX) ? err_q + 1'b1 : err_q;
  end

  always_comb begin
    state_n = state_q;
    op_n    = op_q;
    hold_n  = hold_q;
    vec_n   = vec_q;
    err_n   = err_q;
    pass_n  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_n    = op_sel;
          err_n   = '0;
          pass_n  = 1'b0;
          vec_n   = '0;
          hold_n  = HOLD_LOAD;
          state_n = S_APPLY;
        end
      end
      S_APPLY: begin
        if (hold_q == '0) state_n = S_SAMPLE;
        else              hold_n  = hold_q - 1'b1;
      end
      S_SAMPLE: begin
        err_n = err_upd;
`ifdef GATE_SEQ_STOP_ON_ERR_EN
        if (mismatch || vec_q == VEC_LAST) begin
`else
        if (vec_q == VEC_LAST) begin
`endif
          // pass is settled on entry to DONE so it is already valid alongside done.
          pass_n  = (err_upd == '0);
          state_n = S_DONE;
        end else begin
          vec_n   = vec_q + 1'b1;
          hold_n  = HOLD_LOAD;
          state_n = S_APPLY;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // The applied vector is the index itself, so it freezes with vec_idx after a sweep.
  assign dut_in    = vec_q;
  assign vec_idx   = vec_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign err_cnt   = err_q;
  assign state_dbg = state_q;

endmodule

// File: doc/gate_test_sequencer.md
Name: gate_test_sequencer

Overview:
- Sequencer for the codebase's small combinational gate datapaths (AND/OR/XOR/NAND units).
- Walks the gate's inputs through every combination, holds each vector for a programmable number of cycles, and samples the gate output.
- Compares each sample against the expected function and reports pass/fail and an error count.
- Replaces hand-written delay-based stimulus with a synthesizable, clocked controller usable on board.

Parameters:
- N_IN, 2, number of gate inputs driven; vectors 0 .. 2^N_IN-1.
- HOLD_CYCLES, 10, cycles each vector is held before sampling; legal range >= 1.
- ERR_W, 8, width of the error counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a sweep; ignored while busy.
- op_sel  input  2  expected function, latched at start: 0=AND, 1=OR, 2=XOR, 3=NAND.
- dut_in  output  N_IN  vector driven to the gate under test.
- dut_out  input  1  gate output, combinational from dut_in.
- busy  output  1  high from the cycle after start is accepted until DONE is left.
- done  output  1  one-cycle pulse at end of sweep.
- pass  output  1  registered; 1 if the last sweep had zero mismatches; held until the next start.
- err_cnt  output  ERR_W  mismatches in the current/last sweep; saturating.
- vec_idx  output  N_IN  index of the vector currently applied.

Behaviour:
- Reset (async, rst_n=0): state IDLE. dut_in=0, vec_idx=0, busy=0, done=0, pass=0, err_cnt=0, hold counter=0, latched op=0. Takes effect immediately, including mid-sweep; no partial result is reported.
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE:
  - start=1 latches op_sel, clears err_cnt and pass, sets vec_idx=0, loads hold counter with HOLD_CYCLES-1, and moves to APPLY.
  - busy=0.
- APPLY:
  - dut_in=vec_idx; busy=1.
  - Counter decrements each cycle; at 0, move to SAMPLE.
  - Total HOLD_CYCLES cycles per vector.
- SAMPLE (1 cycle):
  - dut_in stays stable.
  - Expected = &vec, |vec, ^vec, or ~&vec per the latched op.
  - If dut_out != expected, err_cnt increments, saturating at 2^ERR_W-1.
  - If vec_idx == 2^N_IN-1, go to DONE. Otherwise vec_idx+1, reload the counter, and go to APPLY.
- DONE (1 cycle):
  - done=1, busy=1; pass <= (err_cnt==0), using the updated count including the final sample.
  - Next state IDLE. dut_in holds its last vector until the next start.
- Latency: the edge that samples start is edge k. done is high in the cycle after edge k + 2^N_IN*(HOLD_CYCLES+1).
  - Defaults: 44 edges, 45th cycle.
- start:
  - Ignored in APPLY/SAMPLE/DONE; it is not queued.
  - start in the same cycle DONE exits is ignored; one IDLE cycle is required.
- op_sel changes during a sweep have no effect.
- vec_idx does not wrap mid-sweep; the sweep ends at the maximum index.

Optional Feature:
- Macro: GATE_SEQ_STOP_ON_ERR_EN.
- Defined: the first mismatch in SAMPLE goes directly to DONE.
  - vec_idx and dut_in freeze at the failing vector through DONE and IDLE until the next start.
  - err_cnt=1, pass=0.
- Undefined: the full sweep always completes; err_cnt reflects all mismatches.

Test Plan:
- Reset mid-sweep: defaults, op=AND, correct AND model; assert rst_n=0 at cycle 20 after start. All outputs 0 immediately, state IDLE. A new start then gives done 44 cycles later with pass=1.
- Clean AND sweep: defaults, correct AND model, start with op_sel=0.
  - dut_in steps 0,1,2,3, each held 11 cycles.
  - done pulses exactly once, 44 edges after start; pass=1, err_cnt=0.
- Mismatched function: model is OR, op_sel=0 (AND). Vectors 1 and 2 mismatch, so err_cnt=2 and pass=0 at done. With GATE_SEQ_STOP_ON_ERR_EN defined: done after vector 1 (22 edges), vec_idx=1, err_cnt=1.
- Stuck-at-1 output with ERR_W=1, N_IN=3, op=AND: err_cnt saturates at 1 and does not wrap; pass=0.
- Start while busy: pulse start at cycles 5 and 30 of a sweep. Exactly one done; the sweep length stays 44; op_sel toggled mid-sweep does not alter results.
- HOLD_CYCLES=1, N_IN=2, NAND model, op=3: done after 8 edges, pass=1; each vector is held 2 cycles.
